// File: rtl/alu_operand_sequencer_pkg.sv
// Shared constants for the operand sequencer and the ALU selector.
// State encodings, f/x/n opcode codes and the opcode bundle type.
package alu_operand_sequencer_pkg;

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_B    = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_SHOW = 3'd4;

  localparam logic [2:0] PASS_A = 3'b000;
  localparam logic [2:0] PASS_B = 3'b001;
  localparam logic [2:0] AND_AB = 3'b010;
  localparam logic [2:0] OR_AB  = 3'b011;
  localparam logic [2:0] XOR_AB = 3'b100;
  localparam logic [2:0] NOT_A  = 3'b101;
  localparam logic [2:0] ADD    = 3'b110;
  localparam logic [2:0] SUB    = 3'b111;

  typedef struct packed {
    logic f;
    logic x;
    logic n;
  } fxn_t;

  function automatic logic [2:0] led_of(
    input logic [2:0] st
  );
    logic [2:0] led;
    led = 3'b000;
    unique case (1'b1)
      st == S_A:  led = 3'b001;
      st == S_B:  led = 3'b010;
      st == S_OP: led = 3'b100;
      default:    led = 3'b000;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/alu_operand_sequencer_btn_debounce.sv
// Two-flop synchronizer, stability counter and one-cycle rising pulse.
// The level only flips after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          db;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      db    <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      pulse <= 1'b0;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        db    <= s2;
        cnt   <= '0;
        pulse <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Stepped A / B / opcode entry in front of the combinational ALU,
// with a one-cycle EXEC settle and a held display register.
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int WIDTH           = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clear,
  input  logic [WIDTH-1:0] result_in,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             f,
  output logic             x,
  output logic             n,
  output logic             operands_valid,
  output logic [WIDTH-1:0] result_q,
  output logic             result_valid,
  output logic [2:0]       state_led
);

  logic       load_pulse;
  logic       clr_s1;
  logic       clr_s2;
  logic [2:0] state;
  fxn_t       opc;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_load),
    .pulse(load_pulse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_s1 <= 1'b0;
      clr_s2 <= 1'b0;
    end else begin
      clr_s1 <= btn_clear;
      clr_s2 <= clr_s1;
    end
  end

  // clear acts like reset for everything except the load debouncer
  always_ff @(posedge clk) begin
    if (rst || clr_s2) begin
      state          <= S_A;
      op_a           <= '0;
      op_b           <= '0;
      opc            <= '0;
      operands_valid <= 1'b0;
      result_q       <= '0;
      result_valid   <= 1'b0;
    end else begin
      unique case (state)
        S_A: begin
          if (load_pulse) begin
            op_a  <= sw;
            state <= S_B;
          end
        end
        S_B: begin
          if (load_pulse) begin
            op_b  <= sw;
            state <= S_OP;
          end
        end
        S_OP: begin
          if (load_pulse) begin
            opc            <= sw[2:0];
            operands_valid <= 1'b1;
            state          <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q     <= result_in;
          result_valid <= 1'b1;
          state        <= S_SHOW;
        end
        S_SHOW: begin
          if (load_pulse) begin
            result_valid   <= 1'b0;
            operands_valid <= 1'b0;
            state          <= S_A;
          end
        end
        default: state <= S_A;
      endcase
    end
  end

  assign f         = opc.f;
  assign x         = opc.x;
  assign n         = opc.n;
  assign state_led = led_of(state);

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Upstream front end of the 6-bit ALU datapath. Converts one 6-bit switch bank and a load push-button into a stepped entry sequence: operand A, then operand B, then the f/x/n opcode.
- Drives the registered operands and opcode into the combinational ALU operation selector, then captures the selected 6-bit result into a stable display register.
- Contains the button synchronizer/debouncer, the entry state machine and the result register.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed before the debounced button level changes (10 ms at 100 MHz).
- WIDTH, 6, operand/result width; only 6 is required to work.

Ports:
- clk  input  1  system clock; single clock domain
- rst  input  1  synchronous, active-high reset
- sw  input  WIDTH  switch bank; used as operand value or opcode (sw[2:0] = {f,x,n})
- btn_load  input  1  raw asynchronous load push-button, active-high
- btn_clear  input  1  raw asynchronous clear button, active-high, not debounced
- result_in  input  WIDTH  selected result returned from the ALU operation selector
- op_a  output  WIDTH  registered operand A to the ALU
- op_b  output  WIDTH  registered operand B to the ALU
- f, x, n  output  1 each  registered opcode bits to the ALU
- operands_valid  output  1  A, B and opcode are complete and stable
- result_q  output  WIDTH  captured ALU result for display
- result_valid  output  1  result_q holds a result for the current operands
- state_led  output  3  one-hot entry-step indicator: 001 = A, 010 = B, 100 = opcode; 000 in EXEC/SHOW

Behaviour:
- Reset (rst high at a clk edge):
  - op_a, op_b, f, x, n, result_q = 0; operands_valid = 0; result_valid = 0.
  - FSM = S_A; state_led = 001.
  - Synchronizer flops, debounced level and debounce counter = 0.
  - rst has priority over every other event, including mid-sequence.
- Button path, btn_load:
  - 2-flop synchronizer.
  - Counter increments while the synchronized level differs from the debounced level. Resets to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
  - load_pulse is high for exactly one cycle on each debounced 0->1 transition. A held button produces one pulse only.
- btn_clear:
  - 2-flop synchronizer only.
  - While its synchronized level is high, it acts as a reset for the FSM, operand, opcode and result registers.
  - It does not reset the btn_load debouncer.
- FSM states:
  - S_A: on load_pulse, op_a <= sw; go to S_B.
  - S_B: on load_pulse, op_b <= sw; go to S_OP.
  - S_OP: on load_pulse, {f,x,n} <= sw[2:0] (sw[5:3] ignored); go to S_EXEC.
  - S_EXEC: lasts exactly one cycle and ignores load_pulse. At the end of this cycle, result_q <= result_in and result_valid <= 1; go to S_SHOW.
  - S_SHOW: holds result_q. On load_pulse, go to S_A and clear result_valid and operands_valid. op_a, op_b and opcode keep their old values until overwritten.
- operands_valid:
  - Goes high on entry to S_EXEC (registered; same edge that loads the opcode).
  - Stays high through S_SHOW; low in S_A, S_B and S_OP.
- Latency:
  - The opcode-load edge is followed by one EXEC cycle, which gives the ALU a full cycle to settle.
  - result_q is valid 2 edges after the load_pulse that carried the opcode.
- The ALU is combinational. Its result_in path must meet a single clk period from op_a/op_b/f/x/n.
- Simultaneous events:
  - clear beats load_pulse.
  - A load_pulse in S_EXEC is discarded. It is not queued.
- Width rules: no arithmetic in this block. All values pass through unmodified; no sign extension.

Decomposition:
- Shared package holds:
  - the state encoding constants S_A, S_B, S_OP, S_EXEC, S_SHOW (3-bit);
  - the opcode constants for the 8 f/x/n codes (PASS_A=000 ... SUB=111), so that the ALU selector and this block agree.
- One natural sub-module: btn_debounce (synchronizer + counter + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated for btn_load.

Test Plan (DEBOUNCE_CYCLES = 4, ALU model: result_in = op_a + op_b when fxn = 110):
- Reset, then three clean presses with sw = 000101, 000011, 000110 -> op_a = 5, op_b = 3, fxn = 110; state_led steps 001->010->100->000; result_q = 8 and result_valid = 1 two cycles after the third pulse.
- btn_load bounce: 1-cycle and 3-cycle glitches, then held high for 10 cycles -> no pulse for the glitches; exactly one load_pulse for the hold; op_a loaded once.
- Held button across 50 cycles in S_A -> exactly one advance to S_B, no further advance until release and re-press.
- btn_clear asserted while in S_OP with op_a = 5 and op_b = 3 -> all registers return to 0, state_led = 001, result_valid = 0; next press loads op_a.
- rst asserted in S_SHOW with result_q = 8 -> result_q = 0, result_valid = 0, operands_valid = 0, FSM in S_A on the next edge.
- Press in S_SHOW -> FSM to S_A, result_valid and operands_valid drop on the same edge, op_a/op_b retain 5/3 until reloaded.
